load_extend_unit: RTL and testbench

LOAD_EXTEND_UNIT -- requirements
Module: load_extend_unit

---
 rtl/load_extend_unit_pkg.sv | 24 ++
 rtl/load_extend_unit_sign_extend.sv | 27 ++
 rtl/load_extend_unit.sv | 146 ++++++++++++++
 tb/tb_load_extend_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_extend_unit_pkg.sv
// Shared definitions for the load extract/extend unit.
//   - req_size encodings (byte / half / word / full)
//   - FSM state encoding (IDLE, WAIT_MEM, RESP)
//   - lane_w(): width of a byte-lane index for a given data width
package load_extend_unit_pkg;

  // req_size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_FULL = 2'b11;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_WAIT_MEM = 2'd1;
  localparam state_t ST_RESP     = 2'd2;

  // Number of bits needed to index a byte lane of a data_w-bit word.
  function automatic int lane_w(input int data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

// File: rtl/load_extend_unit_sign_extend.sv
// sign_extend_n: widens an IN_W-bit field to OUT_W bits.
// Ports:
//   data      in  IN_W   field to widen (LSB-aligned)
//   is_signed in  1      1 = replicate field MSB, 0 = pad with zeros
//   result    out OUT_W  widened field
// When OUT_W <= IN_W the field passes through unchanged.
module sign_extend_n #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  data,
  input  logic             is_signed,
  output logic [OUT_W-1:0] result
);

  generate
    if (OUT_W > IN_W) begin : g_widen
      assign result = {{(OUT_W - IN_W){is_signed & data[IN_W-1]}}, data};
    end else begin : g_pass
      // Nothing to extend, so the signedness control has no effect here.
      logic unused_sign;
      assign unused_sign = is_signed;
      assign result      = data[OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/load_extend_unit.sv
// load_extend_unit: accepts a load-extract request (size, signedness, byte
// offset), waits for the memory word, then returns the selected field
// sign- or zero-extended to DATA_W with a one-cycle res_valid strobe.
// Misaligned requests complete immediately with res_misalign=1, res_data=0.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_size/signed/offset     request fields, latched on acceptance
//   mem_valid/mem_rdata        memory word, used only in WAIT_MEM
//   res_valid                  one-cycle result strobe
//   res_data/res_misalign      result and fault flag, held until next result
//   busy                       high whenever the FSM is not IDLE
module load_extend_unit
  import load_extend_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [lane_w(DATA_W)-1:0] req_offset,
  input  logic                      mem_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic                      res_misalign,
  output logic                      busy
);

  localparam int LW    = lane_w(DATA_W);
  localparam int LANES = DATA_W / 8;

  state_t            state_reg, state_next;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [LW-1:0]     offset_reg;
  logic [DATA_W-1:0] res_data_reg;
  logic              res_misalign_reg;

  logic              accept;
  logic              misalign_in;
  logic [LW-1:0]     base_lane;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext_field [3];
  logic [DATA_W-1:0] ext_data;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [LW-1:0] off);
    case (size)
      SIZE_HALF: return off[0];
      SIZE_WORD: return |off[1:0];
      SIZE_FULL: return |off;
      default:   return 1'b0;
    endcase
  endfunction

  assign req_ready    = (state_reg == ST_IDLE);
  assign busy         = (state_reg != ST_IDLE);
  assign res_valid    = (state_reg == ST_RESP);
  assign res_data     = res_data_reg;
  assign res_misalign = res_misalign_reg;

  assign accept      = req_ready & req_valid;
  assign misalign_in = is_misaligned(req_size, req_offset);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (req_valid) state_next = misalign_in ? ST_RESP : ST_WAIT_MEM;
      ST_WAIT_MEM: if (mem_valid) state_next = ST_RESP;
      ST_RESP:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // The selected field always occupies contiguous lanes. Its lowest lane is
  // the offset itself for little-endian; for big-endian the byte at the
  // offset is the most significant one, so the field ends at lane
  // LANES-1-offset and starts nbytes-1 lanes below it. Alignment guarantees
  // the field never wraps past the top of the word.
  always_comb begin
    int nbytes;
    nbytes = LANES;
    case (size_reg)
      SIZE_BYTE: nbytes = 1;
      SIZE_HALF: nbytes = 2;
      SIZE_WORD: nbytes = 4;
      default:   nbytes = LANES;
    endcase
    if (BIG_ENDIAN) base_lane = LW'(LANES - nbytes - int'(offset_reg));
    else            base_lane = offset_reg;
    shifted = mem_rdata >> {base_lane, 3'b000};
  end

  // One extender per field width: 8, 16, 32 bits.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ext
      sign_extend_n #(
        .IN_W  (8 << gi),
        .OUT_W (DATA_W)
      ) u_ext (
        .data      (shifted[(8 << gi)-1:0]),
        .is_signed (signed_reg),
        .result    (ext_field[gi])
      );
    end
  endgenerate

  // Full size is always at lane 0, so the shifted word is the raw word.
  always_comb begin
    ext_data = shifted;
    case (size_reg)
      SIZE_BYTE: ext_data = ext_field[0];
      SIZE_HALF: ext_data = ext_field[1];
      SIZE_WORD: ext_data = ext_field[2];
      default:   ext_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      size_reg         <= SIZE_BYTE;
      signed_reg       <= 1'b0;
      offset_reg       <= '0;
      res_data_reg     <= '0;
      res_misalign_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        size_reg         <= req_size;
        signed_reg       <= req_signed;
        offset_reg       <= req_offset;
        res_misalign_reg <= misalign_in;
        if (misalign_in) res_data_reg <= '0;
      end
      if (state_reg == ST_WAIT_MEM && mem_valid) res_data_reg <= ext_data;
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
module tb_load_extend_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, req_valid, req_signed, mem_valid, sel;
  logic [1:0]  req_size;
  logic [2:0]  req_offset;
  logic [63:0] mem_rdata;

  // sel=0 drives the 32-bit little-endian unit, sel=1 the 64-bit big-endian one
  logic req_valid_a, mem_valid_a, req_valid_b, mem_valid_b;
  assign req_valid_a = req_valid & ~sel;
  assign mem_valid_a = mem_valid & ~sel;
  assign req_valid_b = req_valid & sel;
  assign mem_valid_b = mem_valid & sel;

  logic        req_ready_a, res_valid_a, res_misalign_a, busy_a;
  logic [31:0] res_data_a;
  logic        req_ready_b, res_valid_b, res_misalign_b, busy_b;
  logic [63:0] res_data_b;

  load_extend_unit #(.DATA_W(32), .BIG_ENDIAN(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_size(req_size), .req_signed(req_signed), .req_offset(req_offset[1:0]),
    .mem_valid(mem_valid_a), .mem_rdata(mem_rdata[31:0]), .res_valid(res_valid_a),
    .res_data(res_data_a), .res_misalign(res_misalign_a), .busy(busy_a));

  load_extend_unit #(.DATA_W(64), .BIG_ENDIAN(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_size(req_size), .req_signed(req_signed), .req_offset(req_offset),
    .mem_valid(mem_valid_b), .mem_rdata(mem_rdata), .res_valid(res_valid_b),
    .res_data(res_data_b), .res_misalign(res_misalign_b), .busy(busy_b));

  logic        obs_ready, obs_valid, obs_mis, obs_busy;
  logic [63:0] obs_data;
  assign obs_ready = sel ? req_ready_b    : req_ready_a;
  assign obs_valid = sel ? res_valid_b    : res_valid_a;
  assign obs_mis   = sel ? res_misalign_b : res_misalign_a;
  assign obs_busy  = sel ? busy_b         : busy_a;
  assign obs_data  = sel ? res_data_b     : {32'd0, res_data_a};

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: read nb bytes at byte addresses off..off+nb-1 of the word,
  // assemble them in memory order, then extend arithmetically.
  function automatic logic [64:0] model(input logic [1:0] size, input logic sgn,
                                        input int off, input logic [63:0] word,
                                        input int dw, input bit be);
    int n, nb, addr, lane, bits;
    logic [63:0] v, mask, b;
    n  = dw / 8;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : n;
    if (off % nb != 0) return {1'b1, 64'd0};
    v = 64'd0;
    for (int k = 0; k < nb; k++) begin
      addr = off + k;
      lane = be ? (n - 1 - addr) : addr;
      b    = {56'd0, word[8*lane +: 8]};
      if (be) v = (v << 8) | b;
      else    v = v | (b << (8 * k));
    end
    bits = 8 * nb;
    if (bits < 64) begin
      mask = (64'd1 << bits) - 64'd1;
      if (sgn && v[bits-1]) v = v | ~mask;
    end
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {1'b0, v};
  endfunction

  task automatic run_txn(input bit s, input logic [1:0] sz, input logic sg, input int off,
                         input logic [63:0] data, input int waits, input bit early_mem);
    logic [64:0] e;
    e = model(sz, sg, off, data, s ? 64 : 32, s);
    sel        = s;
    req_size   = sz;
    req_signed = sg;
    req_offset = 3'(off);
    req_valid  = 1'b1;
    mem_valid  = early_mem;
    mem_rdata  = ~data;
    check_val("ready_idle", 64'(obs_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_valid = 1'b0;
    if (e[64]) begin
      check_val("mis_valid", 64'(obs_valid), 64'd1);
      check_val("mis_flag", 64'(obs_mis), 64'd1);
      check_val("mis_data", obs_data, 64'd0);
      check_val("mis_busy", 64'(obs_busy), 64'd1);
      mem_valid = 1'b1;
      mem_rdata = data;
      repeat (2) @(posedge clk);
      #1;
      mem_valid = 1'b0;
      check_val("mis_late_mem", 64'(obs_valid), 64'd0);
      check_val("mis_hold", obs_data, 64'd0);
    end else begin
      check_val("wait_valid", 64'(obs_valid), 64'd0);
      check_val("wait_busy", 64'(obs_busy), 64'd1);
      for (int w = 0; w < waits; w++) begin
        @(posedge clk); #1;
        check_val("wait_novalid", 64'(obs_valid), 64'd0);
      end
      mem_valid = 1'b1;
      mem_rdata = data;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      mem_rdata = {$urandom, $urandom};
      check_val("res_valid", 64'(obs_valid), 64'd1);
      check_val("res_data", obs_data, e[63:0]);
      check_val("res_mis", 64'(obs_mis), 64'd0);
      @(posedge clk); #1;
      check_val("res_pulse1", 64'(obs_valid), 64'd0);
      check_val("res_held", obs_data, e[63:0]);
      check_val("back_idle", 64'(obs_ready), 64'd1);
    end
    $display("txn sel=%0d size=%0d sgn=%0d off=%0d waits=%0d data=%h exp_mis=%0d exp=%h got=%h",
             s, sz, sg, off, waits, data, e[64], e[63:0], obs_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int accepts, pulses;
    logic [64:0] e;
    logic [63:0] d;
    reset_n = 1'b0; req_valid = 1'b0; mem_valid = 1'b0; sel = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_offset = 3'd0; mem_rdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_val("rst_ready", 64'(obs_ready), 64'd1);
      check_val("rst_valid", 64'(obs_valid), 64'd0);
      check_val("rst_busy", 64'(obs_busy), 64'd0);
      check_val("rst_data", obs_data, 64'd0);
      check_val("rst_mis", 64'(obs_mis), 64'd0);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run_txn(1'b0, 2'd0, 1'b1, 2, 64'h0000_0000_1280_3456, 3, 1'b0);
    run_txn(1'b0, 2'd0, 1'b0, 2, 64'h0000_0000_1280_3456, 3, 1'b0);
    run_txn(1'b0, 2'd1, 1'b1, 2, 64'h0000_0000_8001_0000, 0, 1'b1);
    run_txn(1'b0, 2'd1, 1'b1, 1, 64'h0000_0000_8001_0000, 0, 1'b0);
    run_txn(1'b0, 2'd3, 1'b1, 0, 64'h0000_0000_8765_4321, 1, 1'b0);
    run_txn(1'b1, 2'd2, 1'b1, 4, 64'h0000_0000_F000_0001, 2, 1'b0);
    run_txn(1'b1, 2'd0, 1'b0, 7, 64'hAB00_0000_0000_0001, 1, 1'b0);
    run_txn(1'b1, 2'd1, 1'b1, 6, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
    run_txn(1'b1, 2'd3, 1'b0, 0, 64'hFEDC_BA98_7654_3210, 1, 1'b1);

    // Reset while in WAIT_MEM: result must be abandoned, after leaving a nonzero res_data
    run_txn(1'b0, 2'd0, 1'b1, 2, 64'h0000_0000_1280_3456, 0, 1'b0);
    sel = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_offset = 3'd1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("arst_ready", 64'(obs_ready), 64'd1);
    check_val("arst_busy", 64'(obs_busy), 64'd0);
    check_val("arst_valid", 64'(obs_valid), 64'd0);
    check_val("arst_data", obs_data, 64'd0);
    mem_valid = 1'b1; mem_rdata = 64'h0000_0000_FFFF_FFFF;
    @(posedge clk); #1;
    check_val("arst_mem_ignored", 64'(obs_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req_size = 2'd1; req_offset = 3'd1; req_signed = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_valid = 1'b0;
    check_val("post_rst_accept", 64'(obs_valid), 64'd1);
    check_val("post_rst_mis", 64'(obs_mis), 64'd1);
    @(posedge clk); #1;
    $display("txn reset_mid_wait done total=%0d", total);

    // Back-to-back: req_valid and mem_valid held high continuously
    sel = 1'b1; req_size = 2'd2; req_signed = 1'b1; req_offset = 3'd4;
    d = {$urandom, $urandom};
    e = model(2'd2, 1'b1, 4, d, 64, 1'b1);
    mem_rdata = d; req_valid = 1'b1; mem_valid = 1'b1;
    accepts = 0; pulses = 0;
    for (int i = 0; i < 18; i++) begin
      if (obs_ready) accepts++;
      @(posedge clk); #1;
      if (obs_valid) begin
        pulses++;
        check_val("b2b_data", obs_data, e[63:0]);
      end
    end
    req_valid = 1'b0; mem_valid = 1'b0;
    check_val("b2b_accepts", 64'(accepts), 64'd6);
    check_val("b2b_pulses", 64'(pulses), 64'd6);
    $display("txn back_to_back accepts=%0d pulses=%0d", accepts, pulses);
    @(posedge clk); #1;

    // Randomized traffic on both units
    for (int i = 0; i < 60; i++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      run_txn(s, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              s ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3)),
              {$urandom, $urandom}, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
